// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared Y86 definitions for the hazard/control unit: icodes, status codes,
// the RNONE register id and the controller state encoding.
package y86_pkg;

  localparam int I_HALT  = 'h0;
  localparam int I_NOP   = 'h1;
  localparam int I_RRMOV = 'h2;
  localparam int I_IRMOV = 'h3;
  localparam int I_RMMOV = 'h4;
  localparam int I_MRMOV = 'h5;
  localparam int I_OPQ   = 'h6;
  localparam int I_JXX   = 'h7;
  localparam int I_CALL  = 'h8;
  localparam int I_RET   = 'h9;
  localparam int I_PUSH  = 'hA;
  localparam int I_POP   = 'hB;

  localparam int S_AOK = 0;
  localparam int S_HLT = 1;
  localparam int S_ADR = 2;
  localparam int S_INS = 3;

  // "No register" is the all-ones id for whatever register width is in use.
  function automatic int rnone(input int reg_w);
    return (1 << reg_w) - 1;
  endfunction

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline-side signals seen by the hazard/control unit.
// master = pipeline datapath, slave = hazard controller.
interface pipeline_hazard_ctrl_if #(
  parameter int ICODE_W = 4,
  parameter int REG_W   = 4,
  parameter int STAT_W  = 2,
  parameter int CNT_W   = 32
);
  logic [ICODE_W-1:0] D_icode;
  logic [REG_W-1:0]   d_srcA;
  logic [REG_W-1:0]   d_srcB;
  logic [ICODE_W-1:0] E_icode;
  logic [REG_W-1:0]   E_dstM;
  logic               e_cnd;
  logic [ICODE_W-1:0] M_icode;
  logic [STAT_W-1:0]  m_stat;
  logic [STAT_W-1:0]  W_stat;
  logic               dmem_ready;

  logic F_stall, D_stall, E_stall, M_stall, W_stall;
  logic D_bubble, E_bubble, M_bubble, W_bubble;
  logic set_cc;
  logic halted;
  logic mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_cnd,
           M_icode, m_stat, W_stat, dmem_ready,
    input  F_stall, D_stall, E_stall, M_stall, W_stall,
           D_bubble, E_bubble, M_bubble, W_bubble,
           set_cc, halted, mem_timeout, stall_cnt, bubble_cnt
  );

  modport slave (
    input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_cnd,
           M_icode, m_stat, W_stat, dmem_ready,
    output F_stall, D_stall, E_stall, M_stall, W_stall,
           D_bubble, E_bubble, M_bubble, W_bubble,
           set_cc, halted, mem_timeout, stall_cnt, bubble_cnt
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_wait_timer.sv
// Counts consecutive data-memory wait cycles; flags timeout on the
// WAIT_MAX-th consecutive wait cycle.
module hazard_wait_timer #(
  parameter int WAIT_MAX = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_wait,
  output logic timeout
);

  localparam int CW = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;

  logic [CW-1:0] r_wait_cnt;

  assign timeout = mem_wait && (r_wait_cnt == CW'(WAIT_MAX - 1));

  // Holds at the terminal count; the controller halts on that edge anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_wait_cnt <= '0;
    else if (!mem_wait)
      r_wait_cnt <= '0;
    else if (!timeout)
      r_wait_cnt <= r_wait_cnt + 1'b1;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Y86 five-stage hazard/control unit: stall/bubble/set_cc generation, dmem
// wait timeout and sticky HALT. Perf counters enabled by PIPE_HAZ_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import y86_pkg::*;
#(
  parameter int ICODE_W  = 4,
  parameter int REG_W    = 4,
  parameter int STAT_W   = 2,
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 32
) (
  input logic                   clk,
  input logic                   rst_n,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [REG_W-1:0]  RNONE = REG_W'(rnone(REG_W));
  localparam logic [STAT_W-1:0] AOK   = STAT_W'(S_AOK);

  hz_state_e r_state, w_state_nxt;
  logic      r_mem_timeout;
  logic      w_timeout;

  logic w_load_use, w_mispred, w_ret_hz, w_mem_op, w_mem_wait;
  logic w_m_exc, w_w_exc;
  logic w_f_stall, w_d_stall, w_e_stall, w_m_stall, w_w_stall;
  logic w_d_bubble, w_e_bubble, w_m_bubble, w_w_bubble, w_set_cc;

  assign w_load_use = ((hz.E_icode == ICODE_W'(I_MRMOV)) || (hz.E_icode == ICODE_W'(I_POP)))
                   && (hz.E_dstM != RNONE)
                   && ((hz.E_dstM == hz.d_srcA) || (hz.E_dstM == hz.d_srcB));
  assign w_mispred  = (hz.E_icode == ICODE_W'(I_JXX)) && !hz.e_cnd;
  assign w_ret_hz   = (hz.D_icode == ICODE_W'(I_RET)) || (hz.E_icode == ICODE_W'(I_RET))
                   || (hz.M_icode == ICODE_W'(I_RET));
  assign w_mem_op   = (hz.M_icode == ICODE_W'(I_RMMOV)) || (hz.M_icode == ICODE_W'(I_MRMOV))
                   || (hz.M_icode == ICODE_W'(I_CALL))  || (hz.M_icode == ICODE_W'(I_RET))
                   || (hz.M_icode == ICODE_W'(I_PUSH))  || (hz.M_icode == ICODE_W'(I_POP));
  assign w_m_exc    = (hz.m_stat != AOK);
  assign w_w_exc    = (hz.W_stat != AOK);
  // Faulting memory ops never wait: the exception path takes over instead.
  assign w_mem_wait = w_mem_op && !hz.dmem_ready && !w_m_exc;

  // Timer only sees waits while running so it sits cleared in HALT.
  hazard_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_wait (w_mem_wait && (r_state == RUN)),
    .timeout  (w_timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= RUN;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == RUN && w_timeout)
        r_mem_timeout <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_f_stall   = 1'b0;
    w_d_stall   = 1'b0;
    w_e_stall   = 1'b0;
    w_m_stall   = 1'b0;
    w_w_stall   = 1'b0;
    w_d_bubble  = 1'b0;
    w_e_bubble  = 1'b0;
    w_m_bubble  = 1'b0;
    w_w_bubble  = 1'b0;
    w_set_cc    = 1'b0;
    if (rst_n) begin
      case (r_state)
        RUN: begin
          w_f_stall  = w_load_use | w_ret_hz | w_mem_wait;
          w_d_stall  = w_load_use | w_mem_wait;
          w_e_stall  = w_mem_wait;
          w_m_stall  = w_mem_wait;
          w_w_stall  = w_w_exc;
          w_d_bubble = !w_mem_wait && (w_mispred | (w_ret_hz && !w_load_use));
          w_e_bubble = !w_mem_wait && (w_mispred | w_load_use);
          w_m_bubble = !w_mem_wait && (w_m_exc | w_w_exc);
          w_w_bubble = w_mem_wait && !w_w_exc;
          w_set_cc   = (hz.E_icode == ICODE_W'(I_OPQ)) && !w_m_exc && !w_w_exc && !w_mem_wait;
          if (w_w_exc || w_timeout)
            w_state_nxt = HALT;
        end
        HALT: begin
          w_f_stall = 1'b1;
          w_d_stall = 1'b1;
          w_e_stall = 1'b1;
          w_m_stall = 1'b1;
          w_w_stall = 1'b1;
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  assign hz.F_stall     = w_f_stall;
  assign hz.D_stall     = w_d_stall;
  assign hz.E_stall     = w_e_stall;
  assign hz.M_stall     = w_m_stall;
  assign hz.W_stall     = w_w_stall;
  assign hz.D_bubble    = w_d_bubble;
  assign hz.E_bubble    = w_e_bubble;
  assign hz.M_bubble    = w_m_bubble;
  assign hz.W_bubble    = w_w_bubble;
  assign hz.set_cc      = w_set_cc;
  assign hz.halted      = (r_state == HALT);
  assign hz.mem_timeout = r_mem_timeout;

`ifdef PIPE_HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_bubble_cnt;
  logic             w_any_bubble;

  assign w_any_bubble = w_d_bubble | w_e_bubble | w_m_bubble | w_w_bubble;

  // Saturating, frozen while halted (stalls are forced high there).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (r_state == RUN) begin
      if (w_f_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_any_bubble && (r_bubble_cnt != '1))
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign hz.stall_cnt  = r_stall_cnt;
  assign hz.bubble_cnt = r_bubble_cnt;
`else
  assign hz.stall_cnt  = '0;
  assign hz.bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors push expected
// controls into a queue; a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

  localparam int CW = 16;

  logic clk;
  logic rst_n;

  pipeline_hazard_ctrl_if #(.ICODE_W(4), .REG_W(4), .STAT_W(2), .CNT_W(CW)) hzif ();

  pipeline_hazard_ctrl #(
    .ICODE_W(4), .REG_W(4), .STAT_W(2), .WAIT_MAX(4), .CNT_W(CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hzif)
  );

  typedef struct {
    string        nm;
    logic [9:0]   ctrl;
    logic         hl;
    logic         to;
    logic         cc;
    logic [CW-1:0] sc;
    logic [CW-1:0] bc;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  logic          g_cc = 1'b0;
  logic [CW-1:0] g_sc = '0;
  logic [CW-1:0] g_bc = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ctrl order: {F,D,E,M,W stall, D,E,M,W bubble, set_cc}
  task automatic vec(input string nm, input logic rst,
                     input logic [3:0] di, sa, sb, ei, edm, input logic ecnd,
                     input logic [3:0] mi, input logic [1:0] ms, ws, input logic rdy,
                     input logic [9:0] ctrl, input logic hl, to);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n            = rst;
    hzif.D_icode     = di;
    hzif.d_srcA      = sa;
    hzif.d_srcB      = sb;
    hzif.E_icode     = ei;
    hzif.E_dstM      = edm;
    hzif.e_cnd       = ecnd;
    hzif.M_icode     = mi;
    hzif.m_stat      = ms;
    hzif.W_stat      = ws;
    hzif.dmem_ready  = rdy;
    e.nm = nm; e.ctrl = ctrl; e.hl = hl; e.to = to;
`ifdef PIPE_HAZ_PERF_CNT_EN
    e.cc = g_cc; e.sc = g_sc; e.bc = g_bc;
`else
    e.cc = 1'b1; e.sc = '0; e.bc = '0;
`endif
    q.push_back(e);
    g_cc = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    logic [9:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        act = {hzif.F_stall, hzif.D_stall, hzif.E_stall, hzif.M_stall, hzif.W_stall,
               hzif.D_bubble, hzif.E_bubble, hzif.M_bubble, hzif.W_bubble, hzif.set_cc};
        n_chk++;
        if (act !== e.ctrl) begin
          n_fail++;
          $display("FAIL %s ctrl got %b want %b", e.nm, act, e.ctrl);
        end
        n_chk++;
        if (hzif.halted !== e.hl) begin
          n_fail++;
          $display("FAIL %s halted got %b want %b", e.nm, hzif.halted, e.hl);
        end
        n_chk++;
        if (hzif.mem_timeout !== e.to) begin
          n_fail++;
          $display("FAIL %s mem_timeout got %b want %b", e.nm, hzif.mem_timeout, e.to);
        end
        if (e.cc) begin
          n_chk++;
          if (hzif.stall_cnt !== e.sc || hzif.bubble_cnt !== e.bc) begin
            n_fail++;
            $display("FAIL %s counters got %0d/%0d want %0d/%0d", e.nm,
                     hzif.stall_cnt, hzif.bubble_cnt, e.sc, e.bc);
          end
        end
      end
    end
  end

  initial begin : stim
    int guard;
    rst_n = 1'b0;
    hzif.D_icode = 4'h1; hzif.d_srcA = 4'hF; hzif.d_srcB = 4'hF;
    hzif.E_icode = 4'h1; hzif.E_dstM = 4'hF; hzif.e_cnd = 1'b0;
    hzif.M_icode = 4'h1; hzif.m_stat = 2'd0; hzif.W_stat = 2'd0; hzif.dmem_ready = 1'b1;

    // Reset forces controls low even with a live hazard on the inputs.
    g_cc = 1'b1; g_sc = '0; g_bc = '0;
    vec("rst_hold",    0, 4'h1,4'h3,4'hF, 4'h5,4'h3,0, 4'h1,2'd0,2'd0,1, 10'b00000_0000_0, 0,0);
    vec("lu_srcA",     1, 4'h1,4'h3,4'hF, 4'h5,4'h3,0, 4'h1,2'd0,2'd0,1, 10'b11000_0100_0, 0,0);
    vec("lu_rnone",    1, 4'h1,4'hF,4'hF, 4'h5,4'hF,0, 4'h1,2'd0,2'd0,1, 10'b00000_0000_0, 0,0);
    vec("lu_pop_srcB", 1, 4'h1,4'hF,4'h2, 4'hB,4'h2,0, 4'h1,2'd0,2'd0,1, 10'b11000_0100_0, 0,0);
    vec("lu_nonload",  1, 4'h1,4'h3,4'hF, 4'h2,4'h3,0, 4'h1,2'd0,2'd0,1, 10'b00000_0000_0, 0,0);
    vec("mispred",     1, 4'h1,4'hF,4'hF, 4'h7,4'hF,0, 4'h1,2'd0,2'd0,1, 10'b00000_1100_0, 0,0);
    vec("jxx_taken",   1, 4'h1,4'hF,4'hF, 4'h7,4'hF,1, 4'h1,2'd0,2'd0,1, 10'b00000_0000_0, 0,0);
    vec("ret_lu",      1, 4'h9,4'h3,4'hF, 4'h5,4'h3,0, 4'h1,2'd0,2'd0,1, 10'b11000_0100_0, 0,0);
    vec("ret_D",       1, 4'h9,4'hF,4'hF, 4'h1,4'hF,0, 4'h1,2'd0,2'd0,1, 10'b10000_1000_0, 0,0);
    vec("ret_M",       1, 4'h1,4'hF,4'hF, 4'h1,4'hF,0, 4'h9,2'd0,2'd0,1, 10'b10000_1000_0, 0,0);
    vec("opq",         1, 4'h1,4'hF,4'hF, 4'h6,4'hF,0, 4'h1,2'd0,2'd0,1, 10'b00000_0000_1, 0,0);
    // Three waits then completion: below timeout, everything releases together.
    for (int i = 0; i < 3; i++)
      vec("wait",      1, 4'h1,4'hF,4'hF, 4'h6,4'hF,0, 4'h5,2'd0,2'd0,0, 10'b11110_0001_0, 0,0);
    vec("wait_done",   1, 4'h1,4'hF,4'hF, 4'h6,4'hF,0, 4'h5,2'd0,2'd0,1, 10'b00000_0000_1, 0,0);
    vec("mexc_nowait", 1, 4'h1,4'hF,4'hF, 4'h6,4'hF,0, 4'h4,2'd1,2'd0,0, 10'b00000_0010_0, 0,0);
    // Timeout after four consecutive waits.
    for (int i = 0; i < 4; i++)
      vec("to_wait",   1, 4'h1,4'hF,4'hF, 4'h1,4'hF,0, 4'h5,2'd0,2'd0,0, 10'b11110_0001_0, 0,0);
    vec("to_halt",     1, 4'h1,4'hF,4'hF, 4'h7,4'hF,0, 4'h1,2'd0,2'd0,1, 10'b11111_0000_0, 1,1);
    vec("to_hold",     1, 4'h9,4'h3,4'hF, 4'h5,4'h3,0, 4'h5,2'd0,2'd0,0, 10'b11111_0000_0, 1,1);
    vec("rst_async1",  0, 4'h1,4'hF,4'hF, 4'h7,4'hF,0, 4'h1,2'd0,2'd0,1, 10'b00000_0000_0, 0,0);
    // Writeback exception.
    vec("exc",         1, 4'h1,4'hF,4'hF, 4'h6,4'hF,0, 4'h1,2'd0,2'd2,1, 10'b00001_0010_0, 0,0);
    vec("exc_halt",    1, 4'h1,4'hF,4'hF, 4'h1,4'hF,0, 4'h1,2'd0,2'd0,1, 10'b11111_0000_0, 1,0);
    vec("rst_async2",  0, 4'h1,4'hF,4'hF, 4'h1,4'hF,0, 4'h1,2'd0,2'd0,1, 10'b00000_0000_0, 0,0);
    // Exception during a wait: W_stall beats W_bubble.
    vec("exc_wait",    1, 4'h1,4'hF,4'hF, 4'h6,4'hF,0, 4'h5,2'd0,2'd2,0, 10'b11111_0000_0, 0,0);
    vec("exc_w_halt",  1, 4'h1,4'hF,4'hF, 4'h1,4'hF,0, 4'h1,2'd0,2'd0,1, 10'b11111_0000_0, 1,0);
    vec("rst_async3",  0, 4'h1,4'hF,4'hF, 4'h1,4'hF,0, 4'h1,2'd0,2'd0,1, 10'b00000_0000_0, 0,0);
    // Timeout and W exception on the same edge.
    for (int i = 0; i < 3; i++)
      vec("both_wait", 1, 4'h1,4'hF,4'hF, 4'h1,4'hF,0, 4'h5,2'd0,2'd0,0, 10'b11110_0001_0, 0,0);
    vec("both_last",   1, 4'h1,4'hF,4'hF, 4'h1,4'hF,0, 4'h5,2'd0,2'd3,0, 10'b11111_0000_0, 0,0);
    vec("both_halt",   1, 4'h1,4'hF,4'hF, 4'h1,4'hF,0, 4'h1,2'd0,2'd0,1, 10'b11111_0000_0, 1,1);
    // Performance counters: 5 load-use + 2 mispredict cycles.
    g_cc = 1'b1; g_sc = '0; g_bc = '0;
    vec("p_rst",       0, 4'h1,4'hF,4'hF, 4'h1,4'hF,0, 4'h1,2'd0,2'd0,1, 10'b00000_0000_0, 0,0);
    for (int i = 0; i < 5; i++)
      vec("p_lu",      1, 4'h1,4'h3,4'hF, 4'h5,4'h3,0, 4'h1,2'd0,2'd0,1, 10'b11000_0100_0, 0,0);
    for (int i = 0; i < 2; i++)
      vec("p_mp",      1, 4'h1,4'hF,4'hF, 4'h7,4'hF,0, 4'h1,2'd0,2'd0,1, 10'b00000_1100_0, 0,0);
    g_cc = 1'b1; g_sc = CW'(5); g_bc = CW'(7);
    vec("p_idle",      1, 4'h1,4'hF,4'hF, 4'h1,4'hF,0, 4'h1,2'd0,2'd0,1, 10'b00000_0000_0, 0,0);
    g_cc = 1'b1; g_sc = '0; g_bc = '0;
    vec("p_rst_mid",   0, 4'h1,4'h3,4'hF, 4'h5,4'h3,0, 4'h1,2'd0,2'd0,1, 10'b00000_0000_0, 0,0);

    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending got %0d want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
